// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master data RAM arbiter.
package ram_arb_pkg;
  localparam int RAM_BYTES_DEFAULT = 4096;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] address;
    logic [31:0] writeData;
  } ramReq_t;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] readData;
  } ramResp_t;

  typedef enum logic {MASTER0, MASTER1} masterId_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin core: combinational one-hot grant plus lastGrant register.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       resetN,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output masterId_t  lastGrant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lastGrant == MASTER0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Reset to MASTER1 so master 0 wins the first contention.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)     lastGrant <= MASTER1;
    else if (|grant) lastGrant <= masterId_t'(grant[1]);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported data RAM between LSU (m0) and debug/DMA (m1);
// one access per cycle, one-cycle registered response, error on bad address.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_BYTES = RAM_BYTES_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              m0ReqValid,
  input  logic              m0ReqWrite,
  input  logic [ADDR_W-1:0] m0ReqAddress,
  input  logic [31:0]       m0ReqWriteData,
  output logic              m0ReqReady,
  output logic              m0RespValid,
  output logic [31:0]       m0RespReadData,
  output logic              m0RespError,
  input  logic              m1ReqValid,
  input  logic              m1ReqWrite,
  input  logic [ADDR_W-1:0] m1ReqAddress,
  input  logic [31:0]       m1ReqWriteData,
  output logic              m1ReqReady,
  output logic              m1RespValid,
  output logic [31:0]       m1RespReadData,
  output logic              m1RespError,
  output logic [ADDR_W-1:0] ramAxiWriteAddress,
  output logic [31:0]       ramAxiWriteData,
  output logic              ramAxiWriteValid,
  output logic [ADDR_W-1:0] ramAxiReadAddress,
  input  logic [31:0]       ramAxiReadData
);

  localparam logic [31:0] MAX_ADDR = 32'(RAM_BYTES - 4);

  ramReq_t   req [2];
  ramResp_t  resp [2];
  ramReq_t   sel;
  logic [1:0] grant;
  masterId_t lastGrant;
  logic      gntAny, err, rdOk;

  assign req[0] = '{valid: m0ReqValid, write: m0ReqWrite,
                    address: 32'(m0ReqAddress), writeData: m0ReqWriteData};
  assign req[1] = '{valid: m1ReqValid, write: m1ReqWrite,
                    address: 32'(m1ReqAddress), writeData: m1ReqWriteData};

  rr_arb2 u_arb (
    .clock     (clock),
    .resetN    (resetN),
    .valid     ({req[1].valid, req[0].valid}),
    .grant     (grant),
    .lastGrant (lastGrant)
  );

  assign gntAny = |grant;
  assign sel    = grant[1] ? req[1] : req[0];
  assign err    = (sel.address[1:0] != 2'b00) || (sel.address > MAX_ADDR);
  assign rdOk   = gntAny && !sel.write && !err;

  // Idle cycles drive zeros onto the RAM bus; the strobe is gated by reset.
  assign ramAxiWriteValid   = resetN && gntAny && sel.write && !err;
  assign ramAxiWriteAddress = gntAny ? ADDR_W'(sel.address) : '0;
  assign ramAxiWriteData    = gntAny ? sel.writeData : '0;
  assign ramAxiReadAddress  = gntAny ? ADDR_W'(sel.address) : '0;

  assign m0ReqReady = grant[0];
  assign m1ReqReady = grant[1];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) resp[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        resp[i].valid    <= grant[i];
        resp[i].error    <= grant[i] && err;
        resp[i].readData <= (grant[i] && rdOk) ? ramAxiReadData : '0;
      end
    end
  end

  assign m0RespValid    = resp[0].valid;
  assign m0RespError    = resp[0].error;
  assign m0RespReadData = resp[0].readData;
  assign m1RespValid    = resp[1].valid;
  assign m1RespError    = resp[1].error;
  assign m1RespReadData = resp[1].readData;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter against a shadow-memory model.
module tb_ram_arbiter;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  logic        v [2];
  logic        w [2];
  logic [31:0] a [2];
  logic [31:0] d [2];

  logic        m0ReqReady, m0RespValid, m0RespError;
  logic [31:0] m0RespReadData;
  logic        m1ReqReady, m1RespValid, m1RespError;
  logic [31:0] m1RespReadData;
  logic [31:0] ramAxiWriteAddress, ramAxiWriteData, ramAxiReadAddress, ramAxiReadData;
  logic        ramAxiWriteValid;

  ram_arbiter dut (
    .clock(clock), .resetN(resetN),
    .m0ReqValid(v[0]), .m0ReqWrite(w[0]), .m0ReqAddress(a[0]), .m0ReqWriteData(d[0]),
    .m0ReqReady(m0ReqReady), .m0RespValid(m0RespValid),
    .m0RespReadData(m0RespReadData), .m0RespError(m0RespError),
    .m1ReqValid(v[1]), .m1ReqWrite(w[1]), .m1ReqAddress(a[1]), .m1ReqWriteData(d[1]),
    .m1ReqReady(m1ReqReady), .m1RespValid(m1RespValid),
    .m1RespReadData(m1RespReadData), .m1RespError(m1RespError),
    .ramAxiWriteAddress(ramAxiWriteAddress), .ramAxiWriteData(ramAxiWriteData),
    .ramAxiWriteValid(ramAxiWriteValid), .ramAxiReadAddress(ramAxiReadAddress),
    .ramAxiReadData(ramAxiReadData)
  );

  // Environment RAM: asynchronous read, write at posedge on strobe.
  logic [31:0] mem [1024];
  assign ramAxiReadData = mem[ramAxiReadAddress[11:2]];
  always @(posedge clock) if (ramAxiWriteValid) mem[ramAxiWriteAddress[11:2]] <= ramAxiWriteData;

  // Reference model state
  logic [31:0] shadow [1024];
  int lg;
  int gm;
  int passed = 0;
  int total = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit is_err(logic [31:0] ad);
    return (ad % 4 != 0) || (ad > 32'd4092);
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin v[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0; end
  endtask

  task automatic req(int m, bit wr, logic [31:0] ad, logic [31:0] wd);
    v[m] = 1; w[m] = wr; a[m] = ad; d[m] = wd;
  endtask

  // Starts at a negedge with inputs set; ends at the next negedge.
  task automatic cycle();
    int g;
    bit e;
    bit ev [2];
    bit ee [2];
    logic [31:0] ed [2];
    for (int i = 0; i < 2; i++) begin ev[i] = 0; ee[i] = 0; ed[i] = 0; end
    #2;
    if (v[0] && v[1]) g = 1 - lg;
    else if (v[0])    g = 0;
    else if (v[1])    g = 1;
    else              g = -1;
    chk("ready0", m0ReqReady, g == 0);
    chk("ready1", m1ReqReady, g == 1);
    if (g >= 0) begin
      e = is_err(a[g]);
      chk("wvalid", ramAxiWriteValid, w[g] && !e);
      if (w[g] && !e) begin
        chk("waddr", ramAxiWriteAddress, a[g]);
        chk("wdata", ramAxiWriteData, d[g]);
      end else if (!e) begin
        chk("raddr", ramAxiReadAddress, a[g]);
      end
      ev[g] = 1;
      ee[g] = e;
      if (!e && !w[g]) ed[g] = shadow[a[g][11:2]];
      if (!e && w[g])  shadow[a[g][11:2]] = d[g];
      lg = g;
    end else begin
      chk("idle_wvalid", ramAxiWriteValid, 0);
      chk("idle_waddr", ramAxiWriteAddress, 0);
      chk("idle_wdata", ramAxiWriteData, 0);
      chk("idle_raddr", ramAxiReadAddress, 0);
    end
    gm = g;
    @(posedge clock);
    #1;
    chk("m0_rvalid", m0RespValid, ev[0]);
    chk("m0_rerr", m0RespError, ee[0]);
    chk("m0_rdata", m0RespReadData, ed[0]);
    chk("m1_rvalid", m1RespValid, ev[1]);
    chk("m1_rerr", m1RespError, ee[1]);
    chk("m1_rdata", m1RespReadData, ed[1]);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetN = 0;
    #3;
    chk("rst_m0valid", m0RespValid, 0);
    chk("rst_m1valid", m1RespValid, 0);
    chk("rst_m0data", m0RespReadData, 0);
    chk("rst_m1err", m1RespError, 0);
    chk("rst_wvalid", ramAxiWriteValid, 0);
    @(negedge clock);
    resetN = 1;
    lg = 1;
    gm = -1;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; shadow[i] = mem[i]; end
    idle_inputs();
    lg = 1; gm = -1;
    @(negedge clock);
    do_reset();

    // 1: write then read-back from m0
    idle_inputs(); req(0, 1, 32'h010, 32'hDEADBEEF); cycle();
    idle_inputs(); req(0, 0, 32'h010, 0); cycle();
    idle_inputs(); cycle();

    // 2: sustained contention after reset
    do_reset();
    idle_inputs(); req(0, 0, 32'h000, 0); req(1, 0, 32'h004, 0);
    repeat (4) cycle();

    // 3: error accesses from m1
    idle_inputs(); req(1, 0, 32'h002, 0); cycle();
    idle_inputs(); req(1, 0, 32'h1000, 0); cycle();
    idle_inputs(); req(1, 1, 32'h1000, 32'h55AA55AA); cycle();

    // 4: make m0 last granted, then collide on the top word
    idle_inputs(); req(0, 0, 32'h000, 0); cycle();
    idle_inputs(); req(1, 1, 32'hFFC, 32'h12345678); req(0, 0, 32'hFFC, 0); cycle();
    v[1] = 0; cycle();
    idle_inputs(); cycle();

    // 5: reset pulse between a read handshake and its response
    idle_inputs(); req(0, 0, 32'h010, 0);
    #2; @(posedge clock); #2;
    resetN = 0;
    req(1, 1, 32'h020, 32'hCAFEF00D);
    #1;
    chk("midrst_m0valid", m0RespValid, 0);
    chk("midrst_m0data", m0RespReadData, 0);
    chk("midrst_wvalid", ramAxiWriteValid, 0);
    @(negedge clock);
    resetN = 1; lg = 1; gm = -1;
    idle_inputs(); req(0, 0, 32'h004, 0); req(1, 0, 32'h008, 0); cycle();
    idle_inputs(); cycle();

    // 6: burst of writes from m0, then readback
    for (int k = 0; k < 8; k++) begin idle_inputs(); req(0, 1, 32'h100 + 4 * k, $urandom); cycle(); end
    for (int k = 0; k < 8; k++) begin idle_inputs(); req(0, 0, 32'h100 + 4 * k, 0); cycle(); end

    // Random traffic; a master holds its request until it is granted.
    idle_inputs(); gm = -1;
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        if (gm == i || !v[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          w[i] = 1'($urandom_range(0, 1));
          d[i] = $urandom;
          r = $urandom_range(0, 9);
          if (r == 0)      a[i] = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
          else if (r == 1) a[i] = 32'd4096 + ($urandom_range(0, 255) << 2);
          else if (r < 6)  a[i] = $urandom_range(0, 15) << 2;
          else             a[i] = $urandom_range(1016, 1023) << 2;
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end
endmodule
